pspin_hostmem_ar_splitter: RTL and testbench
============================================

Name: pspin_hostmem_ar_splitter

Overview:
AXI4 read-address/read-data stage placed directly upstream of the PsPIN host-memory DMA adapter's AXI slave port. It splits every INCR read burst from the PsPIN host-memory master into sub-bursts that never cross a SPLIT_BYTES address boundary, so each downstream AR maps to one legal Corundum DMA read descriptor. It then merges the returned R beats back into the original burst, with a single rlast.

Parameters:
ADDR_WIDTH, 64, AXI address width
DATA_WIDTH, 512, AXI data width
ID_WIDTH, 8, AXI ID width
ARUSER_WIDTH, 1, aruser width
RUSER_WIDTH, 1, ruser width
SPLIT_BYTES, 4096, split boundary in bytes; power of two, at least DATA_WIDTH/8
MAX_OUTSTANDING, 8, depth of the sub-burst tracking FIFO; power of two

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
s_axi_arid/araddr/arlen/arsize/arburst  input  ID_WIDTH/ADDR_WIDTH/8/3/2  upstream AR fields
s_axi_arlock/arcache/arprot/arqos/arregion/aruser  input  1/4/3/4/4/ARUSER_WIDTH  latched and copied unchanged onto every sub-burst
s_axi_arvalid  input  1  upstream AR valid
s_axi_arready  output  1  upstream AR ready
s_axi_rid/rdata/rresp/ruser  output  ID_WIDTH/DATA_WIDTH/2/RUSER_WIDTH  upstream R fields
s_axi_rlast  output  1  upstream R last, original-burst boundary only
s_axi_rvalid  output  1  upstream R valid
s_axi_rready  input  1  upstream R ready
m_axi_ar*  output  same widths as s_axi_ar*  downstream AR fields, one per sub-burst
m_axi_arvalid  output  1  downstream AR valid
m_axi_arready  input  1  downstream AR ready
m_axi_rid/rdata/rresp/rlast/ruser/rvalid  input  same widths as s_axi_r*  downstream R
m_axi_rready  output  1  downstream R ready

Behaviour:
- Reset (rstn=0, async): s_axi_arready=0, m_axi_arvalid=0, FIFO empty, FSM=IDLE. Reset mid-split discards the burst; no further AR is issued.
- FSM IDLE: s_axi_arready=1. On AR handshake:
  - latch all fields; beats_rem=arlen+1; cur_addr=araddr.
  - go to ISSUE; m_axi_arvalid rises on the next cycle.
- FSM ISSUE: s_axi_arready=0. Sub-burst computation:
  - bytes_per_beat=1<<arsize; aligned=cur_addr & ~(bytes_per_beat-1).
  - beats_to_bnd=(SPLIT_BYTES-(aligned mod SPLIT_BYTES))>>arsize.
  - n=min(beats_rem, beats_to_bnd); m_axi_araddr=cur_addr (first beat may be unaligned); m_axi_arlen=n-1; m_axi_arid=latched id.
  - Non-INCR bursts (FIXED, WRAP): n=beats_rem, issued unsplit.
  - All arithmetic is done on a 9-bit beat count.
- Each m_axi AR handshake:
  - push {id, final=(n==beats_rem)} into the FIFO.
  - beats_rem-=n; cur_addr=aligned+n*bytes_per_beat.
  - if final, return to IDLE; otherwise present the next sub-burst in the following cycle, keeping arvalid high.
- m_axi_arvalid = pending & !fifo_full.
  - Valid stays stable once asserted: only a push can fill the FIFO, and a push requires a handshake.
  - Simultaneous pop and full: the gate uses the registered full flag, so issue resumes the next cycle.
- R path, combinational pass-through:
  - s_axi_rvalid=m_axi_rvalid; m_axi_rready=s_axi_rready.
  - rdata, rresp and ruser pass through; s_axi_rid=FIFO head id.
  - s_axi_rlast=m_axi_rlast & head.final.
  - Pop the FIFO on an m_axi R handshake with m_axi_rlast=1.
- Downstream returns sub-bursts in issue order; the DMA adapter is one-to-one and in-order.
- R beat arriving with the FIFO empty: passed with s_axi_rlast=0 and no pop. This is a protocol violation, not a recoverable case.
- The AR and R paths are independent: a new upstream AR is accepted while R beats of earlier bursts drain.

Optional Feature:
Macro PSPIN_AR_SPLIT_STATS_EN.
- Defined: adds output stat_split_bursts (32 bits), incrementing once per accepted upstream AR that produced more than one sub-burst. Also adds output stat_fifo_full_cycles (32 bits), counting cycles where pending & fifo_full. Both wrap at 2^32 and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- araddr=0x1000, arlen=63, arsize=6, INCR -> one m AR at 0x1000 len 63; s_axi_rlast only on beat 64.
- araddr=0x1F80, arlen=3, arsize=6 -> m ARs 0x1F80 len 1 and 0x2000 len 1; s_axi_rlast only on 4th beat; rid is the original on all beats.
- araddr=0x0, arlen=255, arsize=6 -> 4 m ARs, each len 63, at 0x0, 0x1000, 0x2000, 0x3000, back-to-back with m_axi_arready=1; 256 R beats, a single rlast.
- Unaligned araddr=0x0FF0, arlen=1, arsize=6 -> m ARs 0x0FF0 len 0 and 0x1000 len 0; FIXED burst at 0x0FC0, arlen=3 -> one AR, len 3, unsplit.
- MAX_OUTSTANDING=2, R held off, a 4-sub-burst AR -> m_axi_arvalid low after 2 issues; after the first R rlast pops an entry, issue resumes the next cycle.
- rstn=0 asserted during the ISSUE state -> same cycle m_axi_arvalid=0 and s_axi_arready=0; after release, s_axi_arready=1 and the FIFO is empty.

Source files
------------

// File: rtl/pspin_hostmem_ar_splitter.sv
// AXI4 read splitter: cuts INCR bursts at SPLIT_BYTES boundaries and re-merges R beats under one rlast.
// AR: first sub-burst 1 cycle after accept, then back-to-back; R is combinational; AR stalls while tracking FIFO is full. Stats: PSPIN_AR_SPLIT_STATS_EN.
module pspin_hostmem_ar_splitter_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_empty,
    output logic             o_full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_cnt;

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_empty    = (r_cnt == '0);
    assign o_full     = (r_cnt == (PTR_W + 1)'(DEPTH));
endmodule

module pspin_hostmem_ar_splitter #(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int ID_WIDTH        = 8,
    parameter int ARUSER_WIDTH    = 1,
    parameter int RUSER_WIDTH     = 1,
    parameter int SPLIT_BYTES     = 4096,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic [3:0]              s_axi_arregion,
    input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic [RUSER_WIDTH-1:0]  s_axi_ruser,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arqos,
    output logic [3:0]              m_axi_arregion,
    output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic [RUSER_WIDTH-1:0]  m_axi_ruser,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
`ifdef PSPIN_AR_SPLIT_STATS_EN
    ,
    output logic [31:0]             stat_split_bursts,
    output logic [31:0]             stat_fifo_full_cycles
`endif
);
    localparam int SPLIT_LOG2 = $clog2(SPLIT_BYTES);
    localparam int BND_W      = (SPLIT_LOG2 + 1 > 10) ? SPLIT_LOG2 + 1 : 10;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_active;
    logic [ID_WIDTH-1:0]     r_id;
    logic [2:0]              r_size;
    logic [1:0]              r_burst;
    logic                    r_lock;
    logic [3:0]              r_cache;
    logic [2:0]              r_prot;
    logic [3:0]              r_qos;
    logic [3:0]              r_region;
    logic [ARUSER_WIDTH-1:0] r_user;
    logic [8:0]              r_beats_rem;
    logic [ADDR_WIDTH-1:0]   r_cur_addr;

    logic                    w_idle, w_pending, w_s_hs, w_m_hs, w_final, w_pop;
    logic [ADDR_WIDTH-1:0]   w_beat_mask, w_aligned, w_next_addr;
    logic [BND_W-1:0]        w_bytes_to_bnd, w_beats_to_bnd;
    logic [8:0]              w_n;
    logic                    w_fifo_empty, w_fifo_full;
    logic [ID_WIDTH:0]       w_head;

    always_comb begin
        w_state_nxt = r_state;
        w_idle      = 1'b0;
        w_pending   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_idle = 1'b1;
                if (w_s_hs) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_pending = 1'b1;
                if (w_m_hs && w_final) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Boundary distance is measured from the beat-aligned address so an unaligned first beat still counts as one beat.
    always_comb begin
        w_beat_mask    = (ADDR_WIDTH'(1) << r_size) - ADDR_WIDTH'(1);
        w_aligned      = r_cur_addr & ~w_beat_mask;
        w_bytes_to_bnd = BND_W'(SPLIT_BYTES) - BND_W'(w_aligned[SPLIT_LOG2-1:0]);
        w_beats_to_bnd = w_bytes_to_bnd >> r_size;
        w_n            = r_beats_rem;
        if (r_burst == BURST_INCR && BND_W'(r_beats_rem) > w_beats_to_bnd) w_n = w_beats_to_bnd[8:0];
        w_next_addr    = w_aligned + (ADDR_WIDTH'(w_n) << r_size);
        w_final        = (w_n == r_beats_rem);
    end

    assign s_axi_arready = r_active & w_idle;
    assign m_axi_arvalid = w_pending & ~w_fifo_full;
    assign w_s_hs        = s_axi_arvalid & s_axi_arready;
    assign w_m_hs        = m_axi_arvalid & m_axi_arready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_active    <= 1'b0;
            r_id        <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_lock      <= 1'b0;
            r_cache     <= '0;
            r_prot      <= '0;
            r_qos       <= '0;
            r_region    <= '0;
            r_user      <= '0;
            r_beats_rem <= '0;
            r_cur_addr  <= '0;
        end else begin
            r_active <= 1'b1;
            r_state  <= w_state_nxt;
            if (w_s_hs) begin
                r_id        <= s_axi_arid;
                r_size      <= s_axi_arsize;
                r_burst     <= s_axi_arburst;
                r_lock      <= s_axi_arlock;
                r_cache     <= s_axi_arcache;
                r_prot      <= s_axi_arprot;
                r_qos       <= s_axi_arqos;
                r_region    <= s_axi_arregion;
                r_user      <= s_axi_aruser;
                r_beats_rem <= {1'b0, s_axi_arlen} + 9'd1;
                r_cur_addr  <= s_axi_araddr;
            end else if (w_m_hs) begin
                r_beats_rem <= r_beats_rem - w_n;
                r_cur_addr  <= w_next_addr;
            end
        end
    end

    assign m_axi_arid     = r_id;
    assign m_axi_araddr   = r_cur_addr;
    assign m_axi_arlen    = 8'(w_n - 9'd1);
    assign m_axi_arsize   = r_size;
    assign m_axi_arburst  = r_burst;
    assign m_axi_arlock   = r_lock;
    assign m_axi_arcache  = r_cache;
    assign m_axi_arprot   = r_prot;
    assign m_axi_arqos    = r_qos;
    assign m_axi_arregion = r_region;
    assign m_axi_aruser   = r_user;

    pspin_hostmem_ar_splitter_fifo #(
        .WIDTH (ID_WIDTH + 1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_track_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .i_push     (w_m_hs),
        .i_push_dat ({r_id, w_final}),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_empty    (w_fifo_empty),
        .o_full     (w_fifo_full)
    );

    // A beat with no tracked sub-burst is a downstream protocol error: forward it untagged and never pop.
    assign w_pop        = m_axi_rvalid & s_axi_rready & m_axi_rlast & ~w_fifo_empty;
    assign s_axi_rvalid = m_axi_rvalid;
    assign m_axi_rready = s_axi_rready;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_ruser  = m_axi_ruser;
    assign s_axi_rid    = w_fifo_empty ? m_axi_rid : w_head[ID_WIDTH:1];
    assign s_axi_rlast  = m_axi_rlast & w_head[0] & ~w_fifo_empty;

`ifdef PSPIN_AR_SPLIT_STATS_EN
    logic        r_first_sub;
    logic [31:0] r_stat_split;
    logic [31:0] r_stat_full;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_first_sub  <= 1'b0;
            r_stat_split <= '0;
            r_stat_full  <= '0;
        end else begin
            if (w_s_hs) r_first_sub <= 1'b1;
            else if (w_m_hs) r_first_sub <= 1'b0;
            if (w_m_hs && w_final && !r_first_sub) r_stat_split <= r_stat_split + 32'd1;
            if (w_pending && w_fifo_full) r_stat_full <= r_stat_full + 32'd1;
        end
    end

    assign stat_split_bursts     = r_stat_split;
    assign stat_fifo_full_cycles = r_stat_full;
`endif
endmodule

// File: tb/tb_pspin_hostmem_ar_splitter.sv
// Scoreboard bench for pspin_hostmem_ar_splitter: expected sub-bursts and R beats queued at stimulus, checked at DUT output.
module tb_pspin_hostmem_ar_splitter;
    localparam int SPLIT = 4096;
    localparam int MAXO  = 4;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [7:0]  id;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  cache;
        logic        user;
    } ar_t;

    typedef struct packed {
        logic [7:0] id;
        logic       last;
    } r_t;

    logic         clk = 1'b0;
    logic         rstn;
    logic [7:0]   s_axi_arid;
    logic [63:0]  s_axi_araddr;
    logic [7:0]   s_axi_arlen;
    logic [2:0]   s_axi_arsize;
    logic [1:0]   s_axi_arburst;
    logic         s_axi_arlock;
    logic [3:0]   s_axi_arcache;
    logic [2:0]   s_axi_arprot;
    logic [3:0]   s_axi_arqos;
    logic [3:0]   s_axi_arregion;
    logic [0:0]   s_axi_aruser;
    logic         s_axi_arvalid;
    logic         s_axi_arready;
    logic [7:0]   s_axi_rid;
    logic [511:0] s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rlast;
    logic [0:0]   s_axi_ruser;
    logic         s_axi_rvalid;
    logic         s_axi_rready = 1'b0;
    logic [7:0]   m_axi_arid;
    logic [63:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_arlock;
    logic [3:0]   m_axi_arcache;
    logic [2:0]   m_axi_arprot;
    logic [3:0]   m_axi_arqos;
    logic [3:0]   m_axi_arregion;
    logic [0:0]   m_axi_aruser;
    logic         m_axi_arvalid;
    logic         m_axi_arready = 1'b0;
    logic [7:0]   m_axi_rid = '0;
    logic [511:0] m_axi_rdata = '0;
    logic [1:0]   m_axi_rresp = '0;
    logic         m_axi_rlast = 1'b0;
    logic [0:0]   m_axi_ruser = '0;
    logic         m_axi_rvalid = 1'b0;
    logic         m_axi_rready;
`ifdef PSPIN_AR_SPLIT_STATS_EN
    logic [31:0]  stat_split_bursts;
    logic [31:0]  stat_fifo_full_cycles;
`endif

    ar_t  exp_ar_q[$];
    r_t   exp_r_q[$];
    int   sb_q[$];
    int   ar_cyc_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   ar_done = 0;
    int   ar_budget = 0;
    logic r_hold = 1'b0;
    int   r_beat = 0;
    int   r_dat_cnt = 0;
    int   mon_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pspin_hostmem_ar_splitter #(
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .s_axi_arid     (s_axi_arid),
        .s_axi_araddr   (s_axi_araddr),
        .s_axi_arlen    (s_axi_arlen),
        .s_axi_arsize   (s_axi_arsize),
        .s_axi_arburst  (s_axi_arburst),
        .s_axi_arlock   (s_axi_arlock),
        .s_axi_arcache  (s_axi_arcache),
        .s_axi_arprot   (s_axi_arprot),
        .s_axi_arqos    (s_axi_arqos),
        .s_axi_arregion (s_axi_arregion),
        .s_axi_aruser   (s_axi_aruser),
        .s_axi_arvalid  (s_axi_arvalid),
        .s_axi_arready  (s_axi_arready),
        .s_axi_rid      (s_axi_rid),
        .s_axi_rdata    (s_axi_rdata),
        .s_axi_rresp    (s_axi_rresp),
        .s_axi_rlast    (s_axi_rlast),
        .s_axi_ruser    (s_axi_ruser),
        .s_axi_rvalid   (s_axi_rvalid),
        .s_axi_rready   (s_axi_rready),
        .m_axi_arid     (m_axi_arid),
        .m_axi_araddr   (m_axi_araddr),
        .m_axi_arlen    (m_axi_arlen),
        .m_axi_arsize   (m_axi_arsize),
        .m_axi_arburst  (m_axi_arburst),
        .m_axi_arlock   (m_axi_arlock),
        .m_axi_arcache  (m_axi_arcache),
        .m_axi_arprot   (m_axi_arprot),
        .m_axi_arqos    (m_axi_arqos),
        .m_axi_arregion (m_axi_arregion),
        .m_axi_aruser   (m_axi_aruser),
        .m_axi_arvalid  (m_axi_arvalid),
        .m_axi_arready  (m_axi_arready),
        .m_axi_rid      (m_axi_rid),
        .m_axi_rdata    (m_axi_rdata),
        .m_axi_rresp    (m_axi_rresp),
        .m_axi_rlast    (m_axi_rlast),
        .m_axi_ruser    (m_axi_ruser),
        .m_axi_rvalid   (m_axi_rvalid),
        .m_axi_rready   (m_axi_rready)
`ifdef PSPIN_AR_SPLIT_STATS_EN
        ,
        .stat_split_bursts     (stat_split_bursts),
        .stat_fifo_full_cycles (stat_fifo_full_cycles)
`endif
    );

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Downstream AR slave: ready is rationed by ar_budget, accepted sub-bursts feed the R responder.
    always @(negedge clk) begin
        ar_t e;
        m_axi_arready = (ar_done < ar_budget);
        #1;
        if (rstn && m_axi_arvalid && m_axi_arready) begin
            ar_done++;
            ar_cyc_q.push_back(cyc);
            sb_q.push_back(int'(m_axi_arlen));
            if (exp_ar_q.size() == 0) begin
                check_val("ar_unexpected", 1, 0);
            end else begin
                e = exp_ar_q.pop_front();
                check_val("ar_addr", m_axi_araddr, e.addr);
                check_val("ar_len", m_axi_arlen, e.len);
                check_val("ar_id", m_axi_arid, e.id);
                check_val("ar_size", m_axi_arsize, e.size);
                check_val("ar_burst", m_axi_arburst, e.burst);
                check_val("ar_cache_user", {m_axi_arcache, m_axi_aruser}, {e.cache, e.user});
            end
        end
    end

    // Downstream R responder: in-order beats, rlast at each sub-burst end, garbage rid.
    always @(negedge clk) begin
        s_axi_rready = ($urandom_range(0, 3) != 0);
        if (!r_hold && sb_q.size() > 0) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = {16{32'(r_dat_cnt)}};
            m_axi_rresp  = 2'(r_dat_cnt);
            m_axi_ruser  = 1'(r_dat_cnt);
            m_axi_rid    = 8'(r_dat_cnt) ^ 8'hA5;
            m_axi_rlast  = (r_beat == sb_q[0]);
        end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
        end
        #1;
        if (rstn && m_axi_rvalid && m_axi_rready) begin
            r_dat_cnt++;
            if (m_axi_rlast) begin
                void'(sb_q.pop_front());
                r_beat = 0;
            end else begin
                r_beat++;
            end
        end
    end

    // Upstream R monitor.
    always @(negedge clk) begin
        r_t e;
        #2;
        if (rstn && s_axi_rvalid && s_axi_rready) begin
            if (exp_r_q.size() == 0) begin
                check_val("r_unexpected", 1, 0);
            end else begin
                e = exp_r_q.pop_front();
                check_val("r_id", s_axi_rid, e.id);
                check_val("r_last", s_axi_rlast, e.last);
                check_val("r_data", s_axi_rdata, {16{32'(mon_cnt)}});
                check_val("r_resp_user", {s_axi_rresp, s_axi_ruser}, {2'(mon_cnt), 1'(mon_cnt)});
            end
            mon_cnt++;
        end
    end

    task automatic send_ar(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        ar_t e;
        r_t r;
        logic [63:0] a, prev, sa, bpb;
        int cnt;
        bit ok;
        bpb     = 64'd1 << size;
        e.id    = id;
        e.size  = size;
        e.burst = burst;
        e.cache = id[3:0];
        e.user  = id[0];
        if (burst != 2'b01) begin
            e.addr = addr;
            e.len  = len;
            exp_ar_q.push_back(e);
        end else begin
            sa = addr;
            prev = addr;
            cnt = 1;
            for (int i = 1; i <= int'(len); i++) begin
                a = (prev & ~(bpb - 64'd1)) + bpb;
                if ((a / SPLIT) != (sa / SPLIT)) begin
                    e.addr = sa;
                    e.len  = 8'(cnt - 1);
                    exp_ar_q.push_back(e);
                    sa  = a;
                    cnt = 0;
                end
                cnt++;
                prev = a;
            end
            e.addr = sa;
            e.len  = 8'(cnt - 1);
            exp_ar_q.push_back(e);
        end
        for (int i = 0; i <= int'(len); i++) begin
            r.id   = id;
            r.last = (i == int'(len));
            exp_r_q.push_back(r);
        end
        @(negedge clk);
        s_axi_arid     = id;
        s_axi_araddr   = addr;
        s_axi_arlen    = len;
        s_axi_arsize   = size;
        s_axi_arburst  = burst;
        s_axi_arcache  = id[3:0];
        s_axi_aruser   = id[0];
        s_axi_arprot   = 3'd2;
        s_axi_arvalid  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            if (s_axi_arready) ok = 1'b1;
            @(negedge clk);
        end
        s_axi_arvalid = 1'b0;
        if (!ok) check_val("s_ar_accept_timeout", 0, 1);
    endtask

    task automatic wait_drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (exp_ar_q.size() == 0 && exp_r_q.size() == 0 && sb_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            $display("FAIL drain_%s: %0d AR and %0d R items left", tag, exp_ar_q.size(), exp_r_q.size());
            n_vec++;
            n_err++;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int base;
        bit found;
        rstn           = 1'b0;
        s_axi_arid     = '0;
        s_axi_araddr   = '0;
        s_axi_arlen    = '0;
        s_axi_arsize   = '0;
        s_axi_arburst  = '0;
        s_axi_arlock   = 1'b0;
        s_axi_arcache  = '0;
        s_axi_arprot   = '0;
        s_axi_arqos    = '0;
        s_axi_arregion = '0;
        s_axi_aruser   = '0;
        s_axi_arvalid  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_s_arready", s_axi_arready, 0);
        check_val("rst_m_arvalid", m_axi_arvalid, 0);
        @(negedge clk);
        rstn      = 1'b1;
        ar_budget = 1 << 30;
        repeat (2) @(negedge clk);
        #1;
        check_val("post_rst_arready", s_axi_arready, 1);

        send_ar(8'h11, 64'h1000, 8'd63, 3'd6, 2'b01);
        wait_drain("aligned_page");
        send_ar(8'h22, 64'h1F80, 8'd3, 3'd6, 2'b01);
        wait_drain("cross_page");

        base = ar_cyc_q.size();
        send_ar(8'h33, 64'h0, 8'd255, 3'd6, 2'b01);
        wait_drain("four_pages");
        check_val("b2b_count", ar_cyc_q.size() - base, 4);
        check_val("b2b_span", ar_cyc_q[base + 3] - ar_cyc_q[base], 3);

        send_ar(8'h44, 64'h0FF0, 8'd1, 3'd6, 2'b01);
        wait_drain("unaligned");
        send_ar(8'h55, 64'h0FC0, 8'd3, 3'd6, 2'b00);
        wait_drain("fixed");
        send_ar(8'h67, 64'h0FF8, 8'd3, 3'd2, 2'b01);
        wait_drain("narrow");

        // Tracking FIFO fills with R held off; issue must resume one cycle after the first pop.
        r_hold = 1'b1;
        base   = ar_done;
        send_ar(8'h6A, 64'h0F80, 8'd255, 3'd6, 2'b01);
        for (int i = 0; i < 200 && ar_done < base + MAXO; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        #3;
        check_val("stall_arvalid", m_axi_arvalid, 0);
        check_val("stall_issued", ar_done - base, MAXO);
        r_hold = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            #3;
            if (m_axi_rvalid && m_axi_rready && m_axi_rlast) found = 1'b1;
        end
        check_val("stall_pop_seen", found, 1);
        check_val("pop_cycle_arvalid", m_axi_arvalid, 0);
        @(negedge clk);
        #3;
        check_val("resume_arvalid", m_axi_arvalid, 1);
        wait_drain("stall");

        // Reset while the second sub-burst is pending and the first sits in the FIFO.
        r_hold    = 1'b1;
        ar_budget = ar_done + 1;
        send_ar(8'h77, 64'h1F80, 8'd3, 3'd6, 2'b01);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #3;
            if (ar_done == ar_budget && m_axi_arvalid) found = 1'b1;
        end
        check_val("rst_issue_reached", found, 1);
        rstn = 1'b0;
        #1;
        check_val("midrst_m_arvalid", m_axi_arvalid, 0);
        check_val("midrst_s_arready", s_axi_arready, 0);
        exp_ar_q.delete();
        exp_r_q.delete();
        sb_q.delete();
        repeat (2) @(negedge clk);
        rstn      = 1'b1;
        r_hold    = 1'b0;
        ar_budget = 1 << 30;
        repeat (2) @(negedge clk);
        #1;
        check_val("rel_s_arready", s_axi_arready, 1);
        check_val("rel_m_arvalid", m_axi_arvalid, 0);
        send_ar(8'h88, 64'h1F80, 8'd3, 3'd6, 2'b01);
        wait_drain("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
        $fatal(1, "watchdog");
    end
endmodule
